// File: rtl/cpxdiv_pkg.sv
// Shared encodings and widths for the complex-divider issue/collect sequencer.
package cpxdiv_pkg;

  localparam int OP_W  = 16;
  localparam int RES_W = 32;

  localparam logic [RES_W-1:0] SAT_VAL = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_ARM   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/cpxdiv_seq_outreg.sv
// Result holding register for the sequencer: valid/ready output stage,
// delivered-operation counter and error flag capture.
module cpxdiv_seq_outreg
  import cpxdiv_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [RES_W-1:0] load_rey,
  input  logic [RES_W-1:0] load_imy,
  input  logic             load_err,
  input  logic [TAG_W-1:0] load_tag,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [RES_W-1:0] out_rey,
  output logic [RES_W-1:0] out_imy,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  logic fire;
  assign fire = out_valid & out_ready;

  // A load on the same edge as a handshake keeps valid high (zero-divisor reissue).
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_rey   <= '0;
      out_imy   <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
      op_count  <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_rey   <= load_rey;
        out_imy   <= load_imy;
        out_tag   <= load_tag;
        out_err   <= load_err;
      end else if (fire) begin
        out_valid <= 1'b0;
      end
      if (fire) op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cpxdiv_seq.sv
// Issue/collect sequencer for the run/busy complex divider.
// Optional zero-divisor bypass is compiled in with CPXDIV_SEQ_DIVZERO_EN.
//
// state | meaning
// IDLE  | ready for an operand set
// ISSUE | div_run pulse
// ARM   | waiting for divider busy, timeout armed
// WAIT  | divider busy, capture on busy fall
// HOLD  | result presented downstream
module cpxdiv_seq
  import cpxdiv_pkg::*;
#(
  parameter int TAG_W       = 4,
  parameter int ARM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_rea,
  input  logic [OP_W-1:0]  in_ima,
  input  logic [OP_W-1:0]  in_reb,
  input  logic [OP_W-1:0]  in_imb,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_run,
  input  logic             div_busy,
  output logic [OP_W-1:0]  div_rea,
  output logic [OP_W-1:0]  div_ima,
  output logic [OP_W-1:0]  div_reb,
  output logic [OP_W-1:0]  div_imb,
  input  logic [RES_W-1:0] div_rey,
  input  logic [RES_W-1:0] div_imy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_rey,
  output logic [RES_W-1:0] out_imy,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  localparam int TO_W = $clog2(ARM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ARM_TIMEOUT - 1);

  state_t           state, state_nx;
  logic [TO_W-1:0]  to_cnt;
  logic [TAG_W-1:0] tag_q;
  logic             skip_div;
  logic             accept;
  logic             load;
  logic [RES_W-1:0] load_rey, load_imy;
  logic             load_err;
  logic [TAG_W-1:0] load_tag;

`ifdef CPXDIV_SEQ_DIVZERO_EN
  assign skip_div = (in_reb == '0) && (in_imb == '0);
`else
  assign skip_div = 1'b0;
`endif

  assign accept = in_valid & in_ready;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    div_run  = 1'b0;
    load     = 1'b0;
    load_rey = '0;
    load_imy = '0;
    load_err = 1'b0;
    load_tag = tag_q;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = skip_div ? ST_HOLD : ST_ISSUE;
      end
      ST_ISSUE: begin
        div_run  = 1'b1;
        state_nx = ST_ARM;
      end
      ST_ARM: begin
        if (div_busy) begin
          state_nx = ST_WAIT;
        end else if (to_cnt == TO_LAST) begin
          load     = 1'b1;
          load_err = 1'b1;
          state_nx = ST_HOLD;
        end
      end
      ST_WAIT: begin
        if (!div_busy) begin
          load     = 1'b1;
          load_rey = div_rey;
          load_imy = div_imy;
          state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (!in_valid)    state_nx = ST_IDLE;
          else if (skip_div) state_nx = ST_HOLD;
          else               state_nx = ST_ISSUE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // Zero divisor bypasses the divider: saturated result straight into HOLD.
    if (in_valid && in_ready && skip_div) begin
      load     = 1'b1;
      load_rey = SAT_VAL;
      load_imy = SAT_VAL;
      load_err = 1'b1;
      load_tag = in_tag;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      to_cnt  <= '0;
      tag_q   <= '0;
      div_rea <= '0;
      div_ima <= '0;
      div_reb <= '0;
      div_imb <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_ISSUE)    to_cnt <= '0;
      else if (state == ST_ARM) to_cnt <= to_cnt + TO_W'(1);
      if (accept) begin
        div_rea <= in_rea;
        div_ima <= in_ima;
        div_reb <= in_reb;
        div_imb <= in_imb;
        tag_q   <= in_tag;
      end
    end
  end

  cpxdiv_seq_outreg #(
    .TAG_W (TAG_W),
    .CNT_W (CNT_W)
  ) u_outreg (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .load_rey  (load_rey),
    .load_imy  (load_imy),
    .load_err  (load_err),
    .load_tag  (load_tag),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_rey   (out_rey),
    .out_imy   (out_imy),
    .out_tag   (out_tag),
    .out_err   (out_err),
    .op_count  (op_count)
  );

endmodule

// File: tb/tb_cpxdiv_seq.sv
// Self-checking bench for cpxdiv_seq: directed latency/backpressure/timeout/reset
// cases plus a randomized stream scored against an in-order expected queue.
module tb_cpxdiv_seq;

`ifdef CPXDIV_SEQ_DIVZERO_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif
  localparam int T = 8;

  logic        clock, reset;
  logic        in_valid, in_ready;
  logic [15:0] in_rea, in_ima, in_reb, in_imb;
  logic [3:0]  in_tag;
  logic        div_run;
  logic        div_busy = 1'b0;
  logic [15:0] div_rea, div_ima, div_reb, div_imb;
  logic [31:0] div_rey = '0, div_imy = '0;
  logic        out_valid, out_ready;
  logic [31:0] out_rey, out_imy;
  logic [3:0]  out_tag;
  logic        out_err;
  logic [15:0] op_count;

  cpxdiv_seq #(.TAG_W(4), .ARM_TIMEOUT(T), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rea(in_rea), .in_ima(in_ima), .in_reb(in_reb), .in_imb(in_imb), .in_tag(in_tag),
    .div_run(div_run), .div_busy(div_busy),
    .div_rea(div_rea), .div_ima(div_ima), .div_reb(div_reb), .div_imb(div_imb),
    .div_rey(div_rey), .div_imy(div_imy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rey(out_rey), .out_imy(out_imy), .out_tag(out_tag), .out_err(out_err),
    .op_count(op_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Divider model: busy rises the cycle after run and stays high busy_len cycles.
  int          busy_len = 4;
  bit          never_busy = 1'b0;
  bit          use_fixed = 1'b0;
  logic [31:0] fix_rey, fix_imy;
  int          bcnt = 0;
  int          run_count = 0;

  always @(posedge clock) begin
    if (reset) begin
      div_busy <= 1'b0;
      bcnt     <= 0;
    end else if (div_run) begin
      run_count <= run_count + 1;
      div_rey   <= use_fixed ? fix_rey : {div_rea, div_reb};
      div_imy   <= use_fixed ? fix_imy : {div_ima, div_imb};
      if (!never_busy) begin
        div_busy <= 1'b1;
        bcnt     <= busy_len - 1;
      end
    end else if (div_busy) begin
      if (bcnt == 0) div_busy <= 1'b0;
      else           bcnt <= bcnt - 1;
    end
  end

  typedef struct {
    logic [31:0] rey;
    logic [31:0] imy;
    logic [3:0]  tag;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  // Called at a negedge with the DUT idle; returns at the negedge of the cycle after accept.
  task automatic accept_op(input logic [15:0] ra, ia, rb, ib, input logic [3:0] tg);
    in_rea = ra; in_ima = ia; in_reb = rb; in_imb = ib; in_tag = tg;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Cycles counted from the accept cycle (cycle 0) to the first out_valid cycle.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 400) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic deliver();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_stream(input int n, input bit rnd, output int acc_hold);
    int sent = 0, got = 0, cyc = 0;
    bit have_op = 1'b0;
    logic [15:0] ra, ia, rb, ib;
    logic [3:0]  tg;
    exp_t e;
    acc_hold = 0;
    while (got < n && cyc < 20000) begin
      if (sent < n && !have_op) begin
        ra = 16'($urandom); ia = 16'($urandom);
        rb = 16'($urandom); ib = 16'($urandom);
        if (rnd && $urandom_range(0, 7) == 0) begin rb = '0; ib = '0; end
        tg = rnd ? 4'($urandom) : 4'(sent);
        have_op = 1'b1;
      end
      in_rea = ra; in_ima = ia; in_reb = rb; in_imb = ib; in_tag = tg;
      in_valid  = have_op && (!rnd || $urandom_range(0, 3) != 0);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) busy_len = $urandom_range(1, 12);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("str_rey", out_rey, e.rey);
          check_eq("str_imy", out_imy, e.imy);
          check_eq("str_tag", out_tag, e.tag);
          check_eq("str_err", out_err, e.err);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        if (DZ && rb == 0 && ib == 0) begin
          e.rey = 32'h7FFF_FFFF; e.imy = 32'h7FFF_FFFF; e.err = 1'b1;
        end else begin
          e.rey = {ra, rb}; e.imy = {ia, ib}; e.err = 1'b0;
        end
        e.tag = tg;
        exp_q.push_back(e);
        if (out_valid) acc_hold++;
        have_op = 1'b0;
        sent++;
      end
      @(negedge clock);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_eq("stream_done", 64'(got), 64'(n));
  endtask

  int lat, r0, acc_hold, bp_bad, exp_lat;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_rea = '0; in_ima = '0; in_reb = '0; in_imb = '0; in_tag = '0;
    fix_rey = 32'h0002_C000; fix_imy = 32'hFFFF_C000;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_op_count", op_count, 0);
    check_eq("rst_div_run", div_run, 0);
    check_eq("rst_out_err", out_err, 0);
    check_eq("rst_div_rea", div_rea, 0);
    @(negedge clock);

    // Single op with fixed divider results and 80 busy cycles.
    busy_len = 80; use_fixed = 1'b1; r0 = run_count;
    accept_op(16'd3, 16'd4, 16'd1, 16'd2, 4'd5);
    wait_valid(lat);
    check_eq("single_lat", 64'(lat), 83);
    check_eq("single_runs", 64'(run_count - r0), 1);
    check_eq("single_rey", out_rey, 32'h0002_C000);
    check_eq("single_imy", out_imy, 32'hFFFF_C000);
    check_eq("single_tag", out_tag, 5);
    check_eq("single_err", out_err, 0);

    // Backpressure with a pending operand set.
    bp_bad = 0;
    in_rea = 16'd9; in_ima = 16'd9; in_reb = 16'd9; in_imb = 16'd9; in_tag = 4'd9;
    in_valid = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (!out_valid || in_ready || out_rey !== 32'h0002_C000 ||
          out_imy !== 32'hFFFF_C000 || out_tag !== 4'd5) bp_bad++;
    end
    check_eq("bp_stable", 64'(bp_bad), 0);
    check_eq("bp_runs", 64'(run_count - r0), 1);
    in_valid = 1'b0;
    deliver();
    check_eq("bp_op_count", op_count, 1);
    check_eq("bp_valid_drop", out_valid, 0);
    use_fixed = 1'b0;

    // Back-to-back from a fresh reset.
    do_reset();
    busy_len = 4; r0 = run_count;
    run_stream(4, 1'b0, acc_hold);
    check_eq("b2b_no_bubble", 64'(acc_hold), 3);
    check_eq("b2b_op_count", op_count, 4);
    check_eq("b2b_runs", 64'(run_count - r0), 4);

    // Randomized stream.
    run_stream(40, 1'b1, acc_hold);
    @(negedge clock);
    check_eq("rnd_op_count", op_count, 44);

    // Busy never rises.
    never_busy = 1'b1; r0 = run_count;
    accept_op(16'd11, 16'd12, 16'd13, 16'd14, 4'd7);
    wait_valid(lat);
    check_eq("to_lat", 64'(lat), 64'(T + 2));
    check_eq("to_rey", out_rey, 0);
    check_eq("to_imy", out_imy, 0);
    check_eq("to_err", out_err, 1);
    check_eq("to_tag", out_tag, 7);
    check_eq("to_runs", 64'(run_count - r0), 1);
    deliver();
    never_busy = 1'b0;

    // Reset while the divider is busy.
    busy_len = 80;
    accept_op(16'd1, 16'd1, 16'd1, 16'd1, 4'd2);
    lat = 0;
    while (!div_busy && lat < 10) begin @(negedge clock); lat++; end
    check_eq("wr_busy_seen", div_busy, 1);
    repeat (39) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("wr_out_valid", out_valid, 0);
    check_eq("wr_in_ready", in_ready, 1);
    check_eq("wr_op_count", op_count, 0);
    check_eq("wr_div_run", div_run, 0);
    reset = 1'b0;
    @(negedge clock);

    // Zero divisor.
    busy_len = 5; r0 = run_count;
    exp_lat = DZ ? 1 : 8;
    accept_op(16'd7, 16'd9, 16'd0, 16'd0, 4'd3);
    wait_valid(lat);
    check_eq("dz_lat", 64'(lat), 64'(exp_lat));
    check_eq("dz_runs", 64'(run_count - r0), DZ ? 64'd0 : 64'd1);
    check_eq("dz_rey", out_rey, DZ ? 32'h7FFF_FFFF : {16'd7, 16'd0});
    check_eq("dz_imy", out_imy, DZ ? 32'h7FFF_FFFF : {16'd9, 16'd0});
    check_eq("dz_err", out_err, DZ ? 64'd1 : 64'd0);
    check_eq("dz_tag", out_tag, 3);
    deliver();
    check_eq("dz_op_count", op_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
